// File: rtl/soc_test_sequencer_pkg.sv
// Shared types and constants for the SoC self-test sequencer.
// STALL_DETECT_EN adds the stall-detector constants.
package soc_test_sequencer_pkg;

  localparam int unsigned IDX_W = 4;

`ifdef STALL_DETECT_EN
  localparam int unsigned STALL_LIMIT = 16;
  localparam int unsigned STALL_W     = 5;
`endif

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_CRST = 3'd1,
    TS_LOAD = 3'd2,
    TS_RUN  = 3'd3,
    TS_NEXT = 3'd4,
    TS_DONE = 3'd5
  } ts_state_e;

endpackage

// File: rtl/soc_test_sequencer_watchdog.sv
// Saturating cycle counter with clear/enable.
// expired_c flags the enabled cycle on which the count reaches limit (limit=0 expires at once).
module soc_test_sequencer_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign expired_c = en && ((limit == '0) || (count == (limit - W'(1))));

endmodule

// File: rtl/soc_test_sequencer.sv
// Sequences NUM_TESTS on-chip self-test programs: core reset, image load, run-to-PASS/FAIL/timeout.
// Optional macro STALL_DETECT_EN adds a repeated-PC stall detector and a sticky stall output.
module soc_test_sequencer
  import soc_test_sequencer_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_TESTS    = 3,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned TIMEOUT_W    = 24,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_TESTS*XLEN-1:0] pass_addr,
  input  logic [NUM_TESTS*XLEN-1:0] fail_addr,
  input  logic [TIMEOUT_W-1:0]      budget,
  input  logic [XLEN-1:0]           pc,
  input  logic                      pc_valid,
  output logic                      core_rst,
  output logic                      load_req,
  input  logic                      load_ack,
  output logic [IDX_W-1:0]          test_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      all_pass,
  output logic [NUM_TESTS-1:0]      result,
  output logic                      timeout
`ifdef STALL_DETECT_EN
  ,
  output logic                      stall
`endif
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

  ts_state_e              state_q, state_d;
  logic [IDX_W-1:0]       test_idx_d;
  logic [NUM_TESTS-1:0]   result_d;
  logic                   timeout_d, all_pass_d, failed_q, failed_d;
  logic                   core_rst_d, load_req_d, busy_d, done_d;
  logic [XLEN-1:0]        cur_pass, cur_fail;
  logic                   pass_hit, fail_hit;
  logic                   rst_exp_c, budget_exp_c;

  // Select the current test's PASS/FAIL addresses.
  always_comb begin
    cur_pass = '0;
    cur_fail = '0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      if (test_idx == IDX_W'(i)) begin
        cur_pass = pass_addr[i*XLEN +: XLEN];
        cur_fail = fail_addr[i*XLEN +: XLEN];
      end
    end
  end

  assign pass_hit = pc_valid && (pc == cur_pass);
  assign fail_hit = pc_valid && (pc == cur_fail);

  soc_test_sequencer_watchdog #(.W(RW)) u_rst_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != TS_CRST),
    .en        (state_q == TS_CRST),
    .limit     (RW'(RST_CYCLES)),
    .expired_c (rst_exp_c)
  );

  soc_test_sequencer_watchdog #(.W(TIMEOUT_W)) u_budget (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != TS_RUN),
    .en        (state_q == TS_RUN),
    .limit     (budget),
    .expired_c (budget_exp_c)
  );

`ifdef STALL_DETECT_EN
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            last_vld_q, last_vld_d;
  logic            stall_d, stall_cyc, stall_hit;

  // A stall cycle retires the same non-PASS pc as the previous retirement.
  assign stall_cyc = (state_q == TS_RUN) && pc_valid && last_vld_q &&
                     (pc == last_pc_q) && (pc != cur_pass);

  soc_test_sequencer_watchdog #(.W(STALL_W)) u_stall (
    .clk       (clk),
    .rst       (rst),
    .clr       ((state_q != TS_RUN) || (pc_valid && !stall_cyc)),
    .en        (stall_cyc),
    .limit     (STALL_W'(STALL_LIMIT)),
    .expired_c (stall_hit)
  );
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    test_idx_d = test_idx;
    result_d   = result;
    timeout_d  = timeout;
    all_pass_d = all_pass;
    failed_d   = failed_q;
`ifdef STALL_DETECT_EN
    stall_d    = stall;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
`endif

    case (state_q)
      TS_IDLE, TS_DONE: begin
        if (start) begin
          state_d    = TS_CRST;
          test_idx_d = '0;
          result_d   = '0;
          timeout_d  = 1'b0;
          all_pass_d = 1'b0;
          failed_d   = 1'b0;
`ifdef STALL_DETECT_EN
          stall_d    = 1'b0;
          last_vld_d = 1'b0;
`endif
        end
      end
      TS_CRST: begin
        if (rst_exp_c) state_d = TS_LOAD;
      end
      TS_LOAD: begin
        if (load_ack) state_d = TS_RUN;
      end
      TS_RUN: begin
`ifdef STALL_DETECT_EN
        if (pc_valid) begin
          last_pc_d  = pc;
          last_vld_d = 1'b1;
        end
`endif
        // FAIL beats PASS beats budget when several fire together.
        if (fail_hit) begin
          failed_d = 1'b1;
          state_d  = TS_NEXT;
        end else if (pass_hit) begin
          for (int i = 0; i < NUM_TESTS; i++) begin
            if (test_idx == IDX_W'(i)) result_d[i] = 1'b1;
          end
          state_d = TS_NEXT;
        end else if (budget_exp_c) begin
          failed_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = TS_NEXT;
        end
`ifdef STALL_DETECT_EN
        else if (stall_hit) begin
          failed_d = 1'b1;
          stall_d  = 1'b1;
          state_d  = TS_NEXT;
        end
`endif
      end
      TS_NEXT: begin
`ifdef STALL_DETECT_EN
        last_vld_d = 1'b0;
`endif
        if ((failed_q && (STOP_ON_FAIL != 0)) || (test_idx == LAST_IDX)) begin
          state_d    = TS_DONE;
          all_pass_d = &result;
        end else begin
          state_d    = TS_CRST;
          test_idx_d = test_idx + IDX_W'(1);
          failed_d   = 1'b0;
        end
      end
      default: state_d = TS_IDLE;
    endcase

    core_rst_d = (state_d != TS_RUN);
    load_req_d = (state_d == TS_LOAD);
    busy_d     = (state_d == TS_CRST) || (state_d == TS_LOAD) ||
                 (state_d == TS_RUN)  || (state_d == TS_NEXT);
    done_d     = (state_d == TS_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TS_IDLE;
      core_rst <= 1'b1;
      load_req <= 1'b0;
      test_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      all_pass <= 1'b0;
      result   <= '0;
      timeout  <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      core_rst <= core_rst_d;
      load_req <= load_req_d;
      test_idx <= test_idx_d;
      busy     <= busy_d;
      done     <= done_d;
      all_pass <= all_pass_d;
      result   <= result_d;
      timeout  <= timeout_d;
      failed_q <= failed_d;
    end
  end

`ifdef STALL_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall      <= 1'b0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      stall      <= stall_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_soc_test_sequencer.sv
// Bench for soc_test_sequencer: two instances (STOP_ON_FAIL=1 and 0) driven by linear-PC core models;
// per-test outcomes of the stop-on-fail instance are checked against a queue of modelled results.
module tb_soc_test_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NT   = 3;
  localparam int unsigned TW   = 24;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic [3:0]  idx;
    logic        pass;
    logic        to;
    logic [31:0] len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 spin = 1'b0;
  logic [NT*XLEN-1:0]   pass_addr = '0;
  logic [NT*XLEN-1:0]   fail_addr = '0;
  logic [TW-1:0]        budget = '0;

  logic [XLEN-1:0] pc_a, pc_b;
  logic            pc_valid_a, pc_valid_b;
  logic            core_rst_a, core_rst_b, load_req_a, load_req_b;
  logic            load_ack_a = 1'b0, load_ack_b = 1'b0;
  logic [3:0]      test_idx_a, test_idx_b;
  logic            busy_a, busy_b, done_a, done_b, all_pass_a, all_pass_b;
  logic [NT-1:0]   result_a, result_b;
  logic            timeout_a, timeout_b;
`ifdef STALL_DETECT_EN
  logic            stall_a, stall_b;
`endif

  logic [31:0] run_a = '0, run_b = '0;
  int pass_off[NT];
  int fail_off[NT];
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  int run_len = 0;
  logic prev_low = 1'b0;

  soc_test_sequencer #(.XLEN(XLEN), .NUM_TESTS(NT), .RST_CYCLES(2), .TIMEOUT_W(TW), .STOP_ON_FAIL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pass_addr(pass_addr), .fail_addr(fail_addr),
    .budget(budget), .pc(pc_a), .pc_valid(pc_valid_a), .core_rst(core_rst_a),
    .load_req(load_req_a), .load_ack(load_ack_a), .test_idx(test_idx_a), .busy(busy_a),
    .done(done_a), .all_pass(all_pass_a), .result(result_a), .timeout(timeout_a)
`ifdef STALL_DETECT_EN
    , .stall(stall_a)
`endif
  );

  soc_test_sequencer #(.XLEN(XLEN), .NUM_TESTS(NT), .RST_CYCLES(2), .TIMEOUT_W(TW), .STOP_ON_FAIL(0)) dut_nf (
    .clk(clk), .rst(rst), .start(start), .pass_addr(pass_addr), .fail_addr(fail_addr),
    .budget(budget), .pc(pc_b), .pc_valid(pc_valid_b), .core_rst(core_rst_b),
    .load_req(load_req_b), .load_ack(load_ack_b), .test_idx(test_idx_b), .busy(busy_b),
    .done(done_b), .all_pass(all_pass_b), .result(result_b), .timeout(timeout_b)
`ifdef STALL_DETECT_EN
    , .stall(stall_b)
`endif
  );

  // Core models: retire BASE+4*k on run cycle k (or bounce between two PCs when spinning).
  always @(posedge clk) begin
    run_a      <= core_rst_a ? 32'd0 : run_a + 32'd1;
    run_b      <= core_rst_b ? 32'd0 : run_b + 32'd1;
    load_ack_a <= load_req_a && !load_ack_a;
    load_ack_b <= load_req_b && !load_ack_b;
  end

  assign pc_a       = spin ? BASE + {29'd0, run_a[0], 2'b00} : BASE + (run_a << 2);
  assign pc_b       = spin ? BASE + {29'd0, run_b[0], 2'b00} : BASE + (run_b << 2);
  assign pc_valid_a = !core_rst_a;
  assign pc_valid_b = !core_rst_b;

  task automatic set_cfg();
    for (int i = 0; i < NT; i++) begin
      pass_addr[i*XLEN +: XLEN] = BASE + 32'(pass_off[i] * 4);
      fail_addr[i*XLEN +: XLEN] = BASE + 32'(fail_off[i] * 4);
    end
  endtask

  // Model of the stop-on-fail instance: one expected outcome per executed test.
  task automatic expect_seq();
    exp_t e;
    int blen, hit;
    logic is_pass, to_acc;
    to_acc = 1'b0;
    blen = (budget == '0) ? 1 : int'(budget);
    for (int i = 0; i < NT; i++) begin
      is_pass = (pass_off[i] < fail_off[i]);
      hit     = is_pass ? pass_off[i] : fail_off[i];
      e.idx   = 4'(i);
      if (!spin && (hit < blen)) begin
        e.pass = is_pass;
        e.len  = 32'(hit + 1);
      end else begin
        e.pass = 1'b0;
        to_acc = 1'b1;
        e.len  = 32'(blen);
      end
      e.to = to_acc;
      sb.push_back(e);
      if (!e.pass) break;
    end
  endtask

  // One clock; at the falling edge, pop and compare when a RUN period of dut ends.
  task automatic tick();
    exp_t e;
    logic bit_v;
    @(negedge clk);
    if (!rst) begin
      run_len  = 0;
      prev_low = 1'b0;
    end else if (!core_rst_a) begin
      run_len++;
      prev_low = 1'b1;
    end else if (prev_low) begin
      prev_low = 1'b0;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_end: test %0d ended after %0d cycles, required no test end", test_idx_a, run_len);
      end else begin
        e = sb.pop_front();
        bit_v = |(result_a & (NT'(1) << e.idx));
        n_cmp++;
        if (test_idx_a !== e.idx) begin
          n_err++;
          $display("FAIL sb_idx: got %0d, required %0d", test_idx_a, e.idx);
        end
        n_cmp++;
        if (bit_v !== e.pass) begin
          n_err++;
          $display("FAIL sb_pass test %0d: got %0b, required %0b", e.idx, bit_v, e.pass);
        end
        n_cmp++;
        if (timeout_a !== e.to) begin
          n_err++;
          $display("FAIL sb_timeout test %0d: got %0b, required %0b", e.idx, timeout_a, e.to);
        end
        n_cmp++;
        if (32'(run_len) !== e.len) begin
          n_err++;
          $display("FAIL sb_run_len test %0d: got %0d, required %0d", e.idx, run_len, e.len);
        end
      end
      run_len = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int c;
    c = 0;
    while (!(done_a && done_b) && (c < max_cyc)) begin
      tick();
      c++;
    end
    n_cmp++;
    if (!(done_a && done_b)) begin
      n_err++;
      $display("FAIL %s_done_wait: done_a=%0b done_b=%0b after %0d cycles, required both 1", name, done_a, done_b, c);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (core_rst_a !== 1'b1) begin n_err++; $display("FAIL rst_core_rst: got %0b, required 1", core_rst_a); end
    n_cmp++; if (load_req_a !== 1'b0) begin n_err++; $display("FAIL rst_load_req: got %0b, required 0", load_req_a); end
    n_cmp++; if ({busy_a, done_a, all_pass_a, timeout_a} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b, required 0000", {busy_a, done_a, all_pass_a, timeout_a}); end
    n_cmp++; if ({test_idx_a, result_a} !== 7'd0) begin n_err++; $display("FAIL rst_idx_result: got idx %0d result %b, required 0/000", test_idx_a, result_a); end
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (busy_a !== 1'b0 || core_rst_a !== 1'b1) begin n_err++; $display("FAIL idle_hold: busy=%0b core_rst=%0b, required 0/1", busy_a, core_rst_a); end
  endtask

  task automatic test_all_pass();
    int crst, loads, falls, c;
    logic prev_lr, prev_cr, seen_load;
    pass_off = '{20, 35, 50};
    fail_off = '{3000, 3000, 3000};
    budget = TW'(1000);
    spin = 1'b0;
    set_cfg();
    expect_seq();
    crst = 0; loads = 0; falls = 0; c = 0;
    prev_lr = 1'b0; prev_cr = 1'b1; seen_load = 1'b0;
    pulse_start();
    while (!(done_a && done_b) && (c < 2000)) begin
      if (load_req_a) seen_load = 1'b1;
      if (!seen_load && busy_a && core_rst_a) crst++;
      if (load_req_a && !prev_lr) loads++;
      if (!core_rst_a && prev_cr) falls++;
      prev_lr = load_req_a;
      prev_cr = core_rst_a;
      tick();
      c++;
    end
    n_cmp++; if (!(done_a && done_b)) begin n_err++; $display("FAIL allpass_done_wait: done_a=%0b done_b=%0b, required both 1", done_a, done_b); end
    n_cmp++; if (crst != 2) begin n_err++; $display("FAIL allpass_crst_len: got %0d, required 2", crst); end
    n_cmp++; if (loads != 3 || falls != 3) begin n_err++; $display("FAIL allpass_cycles: loads %0d runs %0d, required 3/3", loads, falls); end
    n_cmp++; if (result_a !== 3'b111 || all_pass_a !== 1'b1) begin n_err++; $display("FAIL allpass_result: got %b/%0b, required 111/1", result_a, all_pass_a); end
    n_cmp++; if (busy_a !== 1'b0 || timeout_a !== 1'b0 || test_idx_a !== 4'd2) begin n_err++; $display("FAIL allpass_status: busy %0b to %0b idx %0d, required 0/0/2", busy_a, timeout_a, test_idx_a); end
    n_cmp++; if (result_b !== 3'b111 || all_pass_b !== 1'b1) begin n_err++; $display("FAIL allpass_nf_result: got %b/%0b, required 111/1", result_b, all_pass_b); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL allpass_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_stop_on_fail();
    pass_off = '{20, 3000, 30};
    fail_off = '{3000, 2718, 3000};
    budget = TW'(5000);
    set_cfg();
    expect_seq();
    pulse_start();
    n_cmp++; if (done_a !== 1'b0 || result_a !== 3'b000 || busy_a !== 1'b1) begin n_err++; $display("FAIL restart_clear: done %0b result %b busy %0b, required 0/000/1", done_a, result_a, busy_a); end
    wait_done(8000, "stopfail");
    n_cmp++; if (result_a !== 3'b001 || test_idx_a !== 4'd1) begin n_err++; $display("FAIL stopfail_result: got %b idx %0d, required 001 idx 1", result_a, test_idx_a); end
    n_cmp++; if (all_pass_a !== 1'b0 || timeout_a !== 1'b0) begin n_err++; $display("FAIL stopfail_flags: all_pass %0b timeout %0b, required 0/0", all_pass_a, timeout_a); end
    n_cmp++; if (result_b !== 3'b101 || test_idx_b !== 4'd2 || all_pass_b !== 1'b0) begin n_err++; $display("FAIL runall_result: got %b idx %0d all_pass %0b, required 101/2/0", result_b, test_idx_b, all_pass_b); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stopfail_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_timeout();
    pass_off = '{500, 500, 500};
    fail_off = '{600, 600, 600};
    spin = 1'b1;
    budget = TW'(100);
    set_cfg();
    expect_seq();
    pulse_start();
    wait_done(1000, "to100");
    n_cmp++; if (timeout_a !== 1'b1 || result_a !== 3'b000 || test_idx_a !== 4'd0) begin n_err++; $display("FAIL to100_a: to %0b result %b idx %0d, required 1/000/0", timeout_a, result_a, test_idx_a); end
    n_cmp++; if (timeout_b !== 1'b1 || result_b !== 3'b000 || test_idx_b !== 4'd2) begin n_err++; $display("FAIL to100_b: to %0b result %b idx %0d, required 1/000/2", timeout_b, result_b, test_idx_b); end
    budget = '0;
    expect_seq();
    pulse_start();
    wait_done(200, "to0");
    n_cmp++; if (timeout_a !== 1'b1 || all_pass_a !== 1'b0) begin n_err++; $display("FAIL to0: to %0b all_pass %0b, required 1/0", timeout_a, all_pass_a); end
    // PASS on the last budgeted cycle still wins; one cycle less times out.
    spin = 1'b0;
    pass_off = '{9, 9, 9};
    set_cfg();
    budget = TW'(10);
    expect_seq();
    pulse_start();
    wait_done(200, "edge10");
    n_cmp++; if (timeout_a !== 1'b0 || result_a !== 3'b111 || all_pass_a !== 1'b1) begin n_err++; $display("FAIL edge10: to %0b result %b all_pass %0b, required 0/111/1", timeout_a, result_a, all_pass_a); end
    budget = TW'(9);
    expect_seq();
    pulse_start();
    wait_done(200, "edge9");
    n_cmp++; if (timeout_a !== 1'b1 || result_a !== 3'b000) begin n_err++; $display("FAIL edge9: to %0b result %b, required 1/000", timeout_a, result_a); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL timeout_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    int c;
    pass_off = '{20, 35, 50};
    fail_off = '{3000, 3000, 3000};
    budget = TW'(1000);
    set_cfg();
    expect_seq();
    pulse_start();
    c = 0;
    while (!(test_idx_a == 4'd1 && !core_rst_a) && (c < 300)) begin
      tick();
      c++;
    end
    n_cmp++; if (!(test_idx_a == 4'd1 && !core_rst_a)) begin n_err++; $display("FAIL arst_reach_run: idx %0d core_rst %0b, required 1/0", test_idx_a, core_rst_a); end
    repeat (3) tick();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if ({core_rst_a, load_req_a, busy_a, done_a, all_pass_a, timeout_a} !== 6'b100000) begin n_err++; $display("FAIL arst_flags: got %b, required 100000", {core_rst_a, load_req_a, busy_a, done_a, all_pass_a, timeout_a}); end
    n_cmp++; if (result_a !== 3'b000 || test_idx_a !== 4'd0) begin n_err++; $display("FAIL arst_result: got %b idx %0d, required 000/0", result_a, test_idx_a); end
    tick();
    sb.delete();
    rst = 1'b1;
    repeat (2) tick();
    expect_seq();
    pulse_start();
    wait_done(2000, "arst_rerun");
    n_cmp++; if (result_a !== 3'b111 || test_idx_a !== 4'd2 || all_pass_a !== 1'b1) begin n_err++; $display("FAIL arst_rerun: result %b idx %0d all_pass %0b, required 111/2/1", result_a, test_idx_a, all_pass_a); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL arst_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_same_addr();
    int c;
    pass_off = '{15, 15, 15};
    fail_off = '{15, 15, 15};
    budget = TW'(1000);
    set_cfg();
    expect_seq();
    pulse_start();
    c = 0;
    while (core_rst_a && (c < 30)) begin
      tick();
      c++;
    end
    repeat (3) tick();
    pulse_start();
    n_cmp++; if (busy_a !== 1'b1 || test_idx_a !== 4'd0 || core_rst_a !== 1'b0) begin n_err++; $display("FAIL start_busy: busy %0b idx %0d core_rst %0b, required 1/0/0", busy_a, test_idx_a, core_rst_a); end
    wait_done(500, "same");
    n_cmp++; if (result_a !== 3'b000 || all_pass_a !== 1'b0 || test_idx_a !== 4'd0) begin n_err++; $display("FAIL same_addr_a: result %b all_pass %0b idx %0d, required 000/0/0", result_a, all_pass_a, test_idx_a); end
    n_cmp++; if (result_b !== 3'b000 || test_idx_b !== 4'd2) begin n_err++; $display("FAIL same_addr_b: result %b idx %0d, required 000/2", result_b, test_idx_b); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL same_sb_left: got %0d entries, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_stop_on_fail();
    test_timeout();
    test_async_reset();
    test_same_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
